// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared types for the RV32I data-memory slave: load/store width
//                codes, responder state encoding and wait-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_e;

    localparam int WAIT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/rv32i_dmem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_slave_if
//  Description : Request/response bus between the core load/store unit and
//                the data-memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_dmem_slave_if;

    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWe;
    logic [31:0] iReqAddr;
    logic [2:0]  iReqFunct3;
    logic [31:0] iReqWdata;
    logic        oRspValid;
    logic        iRspReady;
    logic [31:0] oRspRdata;
    logic        oRspErr;

    modport master (
        output iReqValid, iReqWe, iReqAddr, iReqFunct3, iReqWdata, iRspReady,
        input  oReqReady, oRspValid, oRspRdata, oRspErr
    );

    modport slave (
        input  iReqValid, iReqWe, iReqAddr, iReqFunct3, iReqWdata, iRspReady,
        output oReqReady, oRspValid, oRspRdata, oRspErr
    );

endinterface
`default_nettype wire

// File: rtl/rv32i_dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_ram
//  Description : Word-organised data array with per-byte write enables,
//                synchronous write and asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_dmem_ram #(
    parameter int ADDR_W = 8
) (
    input  wire logic              i_clk,
    input  wire logic [3:0]        i_byteWe,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output logic      [31:0]       o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_byteWe[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/rv32i_dmem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_slave
//  Description : Data-memory responder for the RV32I load/store port with
//                programmable wait states, byte-lane stores, extended loads
//                and access-error detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_dmem_slave
    import rv32i_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  wire logic         iClk,
    input  wire logic         iRst,
    rv32i_dmem_slave_if.slave bus
);

    localparam logic [1:0] c_stIdle = ST_IDLE;
    localparam logic [1:0] c_stWait = ST_WAIT;
    localparam logic [1:0] c_stResp = ST_RESP;
    localparam logic [WAIT_CNT_W-1:0] c_waitLast =
        (WAIT_CYC > 0) ? WAIT_CNT_W'(WAIT_CYC - 1) : '0;

    logic [1:0]            r_state;
    logic [WAIT_CNT_W-1:0] r_waitCnt;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [2:0]            r_funct3;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rspRdata;
    logic                  r_rspErr;

    logic        w_idle;
    logic        w_accept;
    logic        w_commit;
    logic        w_we;
    logic [31:0] w_addr;
    logic [2:0]  w_funct3;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic        w_outOfRange;
    logic        w_illegal;
    logic        w_err;
    logic [3:0]  w_strb;
    logic [31:0] w_wdataRep;
    logic [3:0]  w_ramWe;
    logic [31:0] w_ramRdata;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;

    assign w_idle   = (r_state == c_stIdle);
    assign w_accept = w_idle & bus.iReqValid;

    // With zero wait states the access commits on the accept edge itself,
    // so the operands come straight from the bus instead of the latches.
    assign w_we     = w_idle ? bus.iReqWe     : r_we;
    assign w_addr   = w_idle ? bus.iReqAddr   : r_addr;
    assign w_funct3 = w_idle ? bus.iReqFunct3 : r_funct3;
    assign w_wdata  = w_idle ? bus.iReqWdata  : r_wdata;

    assign w_commit = iRst & ((w_accept & (WAIT_CYC == 0)) |
                              ((r_state == c_stWait) & (r_waitCnt == c_waitLast)));

    always_comb begin
        w_misalign = 1'b0;
        case (w_funct3)
            F3_H, F3_HU: w_misalign = w_addr[0];
            F3_W:        w_misalign = (w_addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_outOfRange = |w_addr[31:ADDR_W+2];
    assign w_illegal    = (w_funct3 == 3'b011) | (w_funct3 == 3'b110) | (w_funct3 == 3'b111) |
                          (w_we & ((w_funct3 == F3_BU) | (w_funct3 == F3_HU)));
    assign w_err        = w_misalign | w_outOfRange | w_illegal;

    always_comb begin
        w_strb     = 4'b0000;
        w_wdataRep = w_wdata;
        case (w_funct3)
            F3_B: begin
                w_strb     = 4'b0001 << w_addr[1:0];
                w_wdataRep = {4{w_wdata[7:0]}};
            end
            F3_H: begin
                w_strb     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdataRep = {2{w_wdata[15:0]}};
            end
            F3_W: begin
                w_strb     = 4'b1111;
                w_wdataRep = w_wdata;
            end
            default: begin
                w_strb     = 4'b0000;
                w_wdataRep = w_wdata;
            end
        endcase
    end

    assign w_ramWe = w_strb & {4{w_commit & w_we & ~w_err}};

    rv32i_dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk    (iClk),
        .i_byteWe (w_ramWe),
        .i_addr   (w_addr[ADDR_W+1:2]),
        .i_wdata  (w_wdataRep),
        .o_rdata  (w_ramRdata)
    );

    assign w_shifted = w_ramRdata >> {w_addr[1:0], 3'b000};

    always_comb begin
        w_loadData = '0;
        case (w_funct3)
            F3_B:    w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   w_loadData = {24'h0, w_shifted[7:0]};
            F3_H:    w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   w_loadData = {16'h0, w_shifted[15:0]};
            F3_W:    w_loadData = w_shifted;
            default: w_loadData = '0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state    <= c_stIdle;
            r_waitCnt  <= '0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (w_accept) begin
                        r_waitCnt <= '0;
                        r_state   <= (WAIT_CYC > 0) ? c_stWait : c_stResp;
                    end
                end
                c_stWait: begin
                    if (r_waitCnt == c_waitLast) begin
                        r_state <= c_stResp;
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_CNT_W'(1);
                    end
                end
                c_stResp: begin
                    if (bus.iRspReady) begin
                        r_state <= c_stIdle;
                    end
                end
                default: r_state <= c_stIdle;
            endcase
            if (w_commit) begin
                r_rspRdata <= (w_we | w_err) ? 32'h0 : w_loadData;
                r_rspErr   <= w_err;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_we     <= bus.iReqWe;
            r_addr   <= bus.iReqAddr;
            r_funct3 <= bus.iReqFunct3;
            r_wdata  <= bus.iReqWdata;
        end
    end

    assign bus.oReqReady = w_idle;
    assign bus.oRspValid = (r_state == c_stResp);
    assign bus.oRspRdata = r_rspRdata;
    assign bus.oRspErr   = r_rspErr;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_dmem_slave
//  Description : Self-checking bench for rv32i_dmem_slave against a byte-level
//                memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_dmem_slave;

    localparam int ADDR_W   = 8;
    localparam int WAIT_CYC = 2;
    localparam int WORDS    = 2 ** ADDR_W;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:WORDS-1];

    rv32i_dmem_slave_if bus ();

    rv32i_dmem_slave #(
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: treat memory as bytes, copy size bytes in or out at the byte address.
    task automatic modelAccess(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int  size;
        bit  sext;
        bit  legal;
        int  idx;
        int  off;
        size = 1; sext = 0; legal = 1;
        case (f3)
            3'd0: begin size = 1; sext = 1; end
            3'd1: begin size = 2; sext = 1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; end
            3'd5: begin size = 2; end
            default: legal = 0;
        endcase
        if (we && (f3 == 3'd4 || f3 == 3'd5)) legal = 0;
        err = !legal || ((addr % size) != 0) || (addr >= 32'(WORDS * 4));
        rd  = '0;
        if (!err) begin
            idx = int'(addr / 4);
            off = int'(addr % 4);
            if (we) begin
                for (int i = 0; i < size; i++) mem[idx][(off+i)*8 +: 8] = wd[i*8 +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd[i*8 +: 8] = mem[idx][(off+i)*8 +: 8];
                if (sext && size < 4 && rd[size*8-1])
                    for (int i = size; i < 4; i++) rd[i*8 +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] gotRd, output logic gotErr);
        bit          eErr;
        logic [31:0] eRd;
        int          lat;
        @(negedge iClk);
        bus.iReqValid  = 1'b1;
        bus.iReqWe     = we;
        bus.iReqAddr   = addr;
        bus.iReqFunct3 = f3;
        bus.iReqWdata  = wd;
        bus.iRspReady  = 1'b1;
        checkVal("reqReady", 32'(bus.oReqReady), 32'd1);
        @(posedge iClk);
        @(negedge iClk);
        bus.iReqValid = 1'b0;
        lat = 0;
        while (!bus.oRspValid && lat < 40) begin
            @(negedge iClk);
            lat++;
        end
        checkVal($sformatf("latency@%h", addr), 32'(lat), 32'(WAIT_CYC));
        gotRd  = bus.oRspRdata;
        gotErr = bus.oRspErr;
        modelAccess(we, addr, f3, wd, eErr, eRd);
        checkVal($sformatf("rdata@%h f3=%0d we=%0d", addr, f3, we), gotRd, eRd);
        checkVal($sformatf("err@%h f3=%0d we=%0d", addr, f3, we), 32'(gotErr), 32'(eErr));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] heldRd;
        logic        heldEr;
        logic [31:0] prev;
        bit          eErr;
        logic [31:0] eRd;
        int          lat;

        bus.iReqValid = 0; bus.iReqWe = 0; bus.iReqAddr = '0;
        bus.iReqFunct3 = '0; bus.iReqWdata = '0; bus.iRspReady = 1'b1;

        // Reset
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        checkVal("rst_reqReady", 32'(bus.oReqReady), 32'd1);
        checkVal("rst_rspValid", 32'(bus.oRspValid), 32'd0);
        checkVal("rst_rdata", bus.oRspRdata, 32'd0);
        checkVal("rst_err", 32'(bus.oRspErr), 32'd0);
        iRst = 1'b1;

        // Give every word a known value
        for (int i = 0; i < WORDS; i++) access(1'b1, 32'(i * 4), 3'b010, $urandom, rd, er);

        // Word store/load and sub-word behaviour
        access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er);
        access(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        checkVal("lw10", rd, 32'hDEADBEEF);
        access(1'b1, 32'h11, 3'b000, 32'h00000080, rd, er);
        access(1'b0, 32'h11, 3'b000, 32'h0, rd, er);
        checkVal("lb11", rd, 32'hFFFFFF80);
        access(1'b0, 32'h11, 3'b100, 32'h0, rd, er);
        checkVal("lbu11", rd, 32'h00000080);
        access(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        checkVal("lw10b", rd, 32'hDEAD80EF);
        access(1'b0, 32'h12, 3'b001, 32'h0, rd, er);
        checkVal("lh12", rd, 32'hFFFFDEAD);

        // Error cases
        access(1'b0, 32'h13, 3'b001, 32'h0, rd, er);
        checkVal("lh13_err", 32'(er), 32'd1);
        checkVal("lh13_rd", rd, 32'd0);
        access(1'b1, 32'h12, 3'b010, 32'h0, rd, er);
        checkVal("sw12_err", 32'(er), 32'd1);
        access(1'b0, 32'h10, 3'b010, 32'h0, rd, er);
        checkVal("lw10c", rd, 32'hDEAD80EF);
        access(1'b0, 32'h400, 3'b010, 32'h0, rd, er);
        checkVal("lw400_err", 32'(er), 32'd1);
        access(1'b0, 32'h14, 3'b011, 32'h0, rd, er);
        checkVal("f3_011_err", 32'(er), 32'd1);

        // Backpressure in RESP, with a request held during WAIT/RESP
        @(negedge iClk);
        bus.iReqValid = 1'b1; bus.iReqWe = 1'b0; bus.iReqAddr = 32'h10;
        bus.iReqFunct3 = 3'b010; bus.iRspReady = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        bus.iReqWe = 1'b1; bus.iReqAddr = 32'h34; bus.iReqWdata = 32'hA5A5A5A5;
        lat = 0;
        while (!bus.oRspValid && lat < 40) begin
            @(negedge iClk);
            lat++;
        end
        checkVal("bp_latency", 32'(lat), 32'(WAIT_CYC));
        modelAccess(1'b0, 32'h10, 3'b010, 32'h0, eErr, eRd);
        heldRd = bus.oRspRdata;
        heldEr = bus.oRspErr;
        checkVal("bp_rdata", heldRd, eRd);
        for (int k = 0; k < 5; k++) begin
            @(negedge iClk);
            checkVal("bp_valid", 32'(bus.oRspValid), 32'd1);
            checkVal("bp_hold_rdata", bus.oRspRdata, eRd);
            checkVal("bp_hold_err", 32'(bus.oRspErr), 32'(eErr));
            checkVal("bp_reqReady", 32'(bus.oReqReady), 32'd0);
        end
        bus.iRspReady = 1'b1;
        bus.iReqValid = 1'b0;
        @(negedge iClk);
        checkVal("bp_release_valid", 32'(bus.oRspValid), 32'd0);
        checkVal("bp_release_ready", 32'(bus.oReqReady), 32'd1);
        access(1'b0, 32'h34, 3'b010, 32'h0, rd, er);

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, WORDS * 4 - 1));
            if ($urandom_range(0, 1) == 1) a = (f[0]) ? {a[31:1], 1'b0} : (f[1] ? {a[31:2], 2'b00} : a);
            access(1'($urandom_range(0, 1)), a, f, $urandom, rd, er);
        end

        // Reset in WAIT drops a store
        prev = mem[8];
        @(negedge iClk);
        bus.iReqValid = 1'b1; bus.iReqWe = 1'b1; bus.iReqAddr = 32'h20;
        bus.iReqFunct3 = 3'b010; bus.iReqWdata = 32'h12345678; bus.iRspReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        bus.iReqValid = 1'b0;
        checkVal("rstwait_valid", 32'(bus.oRspValid), 32'd0);
        checkVal("rstwait_ready", 32'(bus.oReqReady), 32'd1);
        repeat (4) @(negedge iClk);
        access(1'b0, 32'h20, 3'b010, 32'h0, rd, er);
        checkVal("rstwait_prestore", rd, prev);

        // Reset in RESP drops the response
        @(negedge iClk);
        bus.iReqValid = 1'b1; bus.iReqWe = 1'b0; bus.iReqAddr = 32'h10;
        bus.iReqFunct3 = 3'b010; bus.iRspReady = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        bus.iReqValid = 1'b0;
        lat = 0;
        while (!bus.oRspValid && lat < 40) begin
            @(negedge iClk);
            lat++;
        end
        checkVal("rstresp_latency", 32'(lat), 32'(WAIT_CYC));
        iRst = 1'b0;
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        bus.iRspReady = 1'b1;
        checkVal("rstresp_valid", 32'(bus.oRspValid), 32'd0);
        checkVal("rstresp_rdata", bus.oRspRdata, 32'd0);
        checkVal("rstresp_err", 32'(bus.oRspErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
